mem_port_ctrl: RTL and testbench

- Request sequencer that sits directly upstream of the 4K x 16 main-memory RAM.
- Accepts read/write requests from the CPU control unit over a valid/ready handshake.
- Drives the RAM's registered-address and strobe inputs (AR, memSrc, memDes, CB), then captures memData after the RAM's one-cycle read latency.
- Returns read data over a valid/ready response channel; signals write completion with a one-cycle pulse.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_port_ctrl.sv | 114 +++++++++++
 tb/tb_mem_port_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants, state encoding and word typedefs for the main-memory
// request sequencer (mem_port_ctrl).
package mem_pkg;

  localparam int MEM_AW = 12;
  localparam int MEM_DW = 16;
  localparam int MEM_LW = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    RSP,
    WR
  } memctl_state_t;

  typedef logic [MEM_AW-1:0] mem_addr_t;
  typedef logic [MEM_DW-1:0] mem_word_t;

endpackage

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: sequences CPU read/write requests onto the 4K x 16 main
// memory strobes (AR/memSrc/memDes/CB), captures memData one cycle after a
// read strobe and returns it on a valid/ready response channel. Writes
// complete with a one-cycle wr_done pulse.
// Optional build macro MEMCTL_BURST_EN: reads of req_len+1 consecutive
// words (address wraps modulo 2**AW).
module mem_port_ctrl
  import mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [LW-1:0] req_len,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          wr_done,
  output logic [AW-1:0] AR,
  output logic          memSrc,
  output logic          memDes,
  output logic [DW-1:0] CB,
  input  logic [DW-1:0] memData
);

  memctl_state_t state;

`ifdef MEMCTL_BURST_EN
  logic [LW-1:0] beats;
`else
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  // Accept only from IDLE and never while reset is asserted.
  assign req_ready = (state == IDLE) && RST_N;

  // Request FSM with registered RAM strobes and response outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      AR        <= '0;
      CB        <= '0;
      rsp_data  <= '0;
      memSrc    <= 1'b0;
      memDes    <= 1'b0;
      rsp_valid <= 1'b0;
      wr_done   <= 1'b0;
`ifdef MEMCTL_BURST_EN
      beats     <= '0;
`endif
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            AR <= req_addr;
            if (req_we) begin
              CB     <= req_wdata;
              memDes <= 1'b1;
              state  <= WR;
            end else begin
              memSrc <= 1'b1;
              state  <= RD;
`ifdef MEMCTL_BURST_EN
              beats  <= req_len;
`endif
            end
          end
        end
        RD: begin
          memSrc <= 1'b0;
          state  <= CAP;
        end
        CAP: begin
          rsp_data  <= memData;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef MEMCTL_BURST_EN
            if (beats != '0) begin
              AR     <= AR + 1'b1;
              memSrc <= 1'b1;
              beats  <= beats - 1'b1;
              state  <= RD;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
        WR: begin
          memDes  <= 1'b0;
          wr_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural 4K x 16 RAM attached.
module tb_mem_port_ctrl;
  import mem_pkg::*;

  localparam int AW = MEM_AW;
  localparam int DW = MEM_DW;
  localparam int LW = MEM_LW;

  logic          CLK;
  logic          RST_N;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          wr_done;
  logic [AW-1:0] AR;
  logic          memSrc;
  logic          memDes;
  logic [DW-1:0] CB;
  logic [DW-1:0] memData;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  mem_port_ctrl #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .wr_done(wr_done), .AR(AR), .memSrc(memSrc), .memDes(memDes),
    .CB(CB), .memData(memData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: registered address/strobes, one-cycle read latency.
  always @(posedge CLK) begin
    if (memDes) ram[AR] <= CB;
    if (memSrc) memData <= ram[AR];
  end

  // Preload through the DUT write path; called and returns at a negedge in IDLE.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    ref_mem[a] = d;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h3AB;
    req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (memSrc !== 1'b0) begin n_err++; $display("FAIL rst_memSrc: got %b want 0", memSrc); end
    n_cmp++; if (memDes !== 1'b0) begin n_err++; $display("FAIL rst_memDes: got %b want 0", memDes); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL rst_wr_done: got %b want 0", wr_done); end
    n_cmp++; if (AR !== 12'h000) begin n_err++; $display("FAIL rst_AR: got %h want 000", AR); end
    req_valid = 1'b0;
    RST_N = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
    @(negedge CLK);
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h123; req_wdata = 16'hBEEF;
    @(negedge CLK);
    req_valid = 1'b0;
    n_cmp++; if (memDes !== 1'b1) begin n_err++; $display("FAIL wr_memDes_hi: got %b want 1", memDes); end
    n_cmp++; if (AR !== 12'h123) begin n_err++; $display("FAIL wr_AR: got %h want 123", AR); end
    n_cmp++; if (CB !== 16'hBEEF) begin n_err++; $display("FAIL wr_CB: got %h want beef", CB); end
    n_cmp++; if (memSrc !== 1'b0) begin n_err++; $display("FAIL wr_memSrc: got %b want 0", memSrc); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_busy_ready: got %b want 0", req_ready); end
    n_cmp++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL wr_done_early: got %b want 0", wr_done); end
    @(negedge CLK);
    n_cmp++; if (memDes !== 1'b0) begin n_err++; $display("FAIL wr_memDes_lo: got %b want 0", memDes); end
    n_cmp++; if (wr_done !== 1'b1) begin n_err++; $display("FAIL wr_done_pulse: got %b want 1", wr_done); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_idle_ready: got %b want 1", req_ready); end
    ref_mem[12'h123] = 16'hBEEF;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h123;
    @(negedge CLK);
    req_valid = 1'b0;
    n_cmp++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL wr_done_single: got %b want 0", wr_done); end
    n_cmp++; if (memSrc !== 1'b1) begin n_err++; $display("FAIL rd_memSrc_hi: got %b want 1", memSrc); end
    n_cmp++; if (AR !== 12'h123) begin n_err++; $display("FAIL rd_AR: got %h want 123", AR); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_c1: got %b want 0", rsp_valid); end
    @(negedge CLK);
    n_cmp++; if (memSrc !== 1'b0) begin n_err++; $display("FAIL rd_memSrc_lo: got %b want 0", memSrc); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_c2: got %b want 0", rsp_valid); end
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rd_valid_lat2: got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_data !== 16'hBEEF) begin n_err++; $display("FAIL rd_data: got %h want beef", rsp_data); end
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rd_valid_drop: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rd_idle_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_backpressure();
    do_write(12'h010, 16'h5A5A);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h010;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_first: got %b want 1", rsp_valid); end
    // A competing write held valid must not be taken while the response waits.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h007; req_wdata = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, rsp_valid); end
      n_cmp++; if (rsp_data !== 16'h5A5A) begin n_err++; $display("FAIL bp_data_hold[%0d]: got %h want 5a5a", i, rsp_data); end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low[%0d]: got %b want 0", i, req_ready); end
      n_cmp++; if (memDes !== 1'b0) begin n_err++; $display("FAIL bp_no_accept[%0d]: got %b want 0", i, memDes); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready: got %b want 1", req_ready); end
    n_cmp++; if (memDes !== 1'b0) begin n_err++; $display("FAIL bp_memDes_after: got %b want 0", memDes); end
  endtask

  task automatic test_reset_mid_read();
    int seen;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'h123;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    n_cmp++; if (memSrc !== 1'b0) begin n_err++; $display("FAIL mid_rst_memSrc: got %b want 0", memSrc); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", req_ready); end
    RST_N = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle: got %b want 1", req_ready); end
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_rst_no_rsp: got %0d valid cycles want 0", seen); end
  endtask

`ifdef MEMCTL_BURST_EN
  task automatic test_burst_wrap();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    do_write(12'hFFE, 16'h1111);
    do_write(12'hFFF, 16'h2222);
    do_write(12'h000, 16'h3333);
    do_write(12'h001, 16'h4444);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 12'hFFE; req_len = 4'd3;
    ea = 12'hFFE;
    ed = 16'h1111;
    for (int b = 0; b < 4; b++) begin
      @(negedge CLK);
      req_valid = 1'b0;
      n_cmp++; if (memSrc !== 1'b1) begin n_err++; $display("FAIL burst_memSrc[%0d]: got %b want 1", b, memSrc); end
      n_cmp++; if (AR !== ea) begin n_err++; $display("FAIL burst_AR[%0d]: got %h want %h", b, AR, ea); end
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL burst_valid[%0d]: got %b want 1", b, rsp_valid); end
      n_cmp++; if (rsp_data !== ed) begin n_err++; $display("FAIL burst_data[%0d]: got %h want %h", b, rsp_data, ed); end
      ea = ea + 1'b1;
      ed = ed + 16'h1111;
    end
    @(negedge CLK);
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL burst_idle: got %b want 1", req_ready); end
    n_cmp++; if (memSrc !== 1'b0) begin n_err++; $display("FAIL burst_end_memSrc: got %b want 0", memSrc); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL burst_end_valid: got %b want 0", rsp_valid); end
    req_len = '0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] d;
    logic [DW-1:0] e;
    logic [AW-1:0] a;
    int wr_cnt, rd_cnt, wr_seen, rsp_seen, overlap;
    wr_cnt = 0; rd_cnt = 0; wr_seen = 0; rsp_seen = 0; overlap = 0;
    for (int i = 0; i < 16; i++) begin
      a = AW'(i);
      d = DW'($urandom);
      do_write(a, d);
    end
    for (int cyc = 0; cyc < 1010; cyc++) begin
      @(negedge CLK);
      if (memSrc && memDes) overlap++;
      if (wr_done) wr_seen++;
      rsp_ready = (cyc >= 1000) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL b2b_extra_rsp: got data %h want no response", rsp_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++; if (rsp_data !== e) begin n_err++; $display("FAIL b2b_data: got %h want %h", rsp_data, e); end
        end
      end
      req_valid = 1'b0;
      if (cyc < 1000 && req_ready && $urandom_range(0, 2) != 0) begin
        a = AW'($urandom_range(0, 15));
        d = DW'($urandom);
        req_valid = 1'b1; req_addr = a; req_wdata = d;
        req_we = ($urandom_range(0, 1) == 1);
        if (req_we) begin
          ref_mem[a] = d;
          wr_cnt++;
        end else begin
          exp_q.push_back(ref_mem[a]);
          rd_cnt++;
        end
      end
    end
    n_cmp++; if (overlap != 0) begin n_err++; $display("FAIL b2b_strobe_overlap: got %0d cycles want 0", overlap); end
    n_cmp++; if (wr_seen != wr_cnt) begin n_err++; $display("FAIL b2b_wr_done_count: got %0d want %0d", wr_seen, wr_cnt); end
    n_cmp++; if (rsp_seen != rd_cnt) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want %0d", rsp_seen, rd_cnt); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_final_idle: got %b want 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_reset_mid_read();
`ifdef MEMCTL_BURST_EN
    test_burst_wrap();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
